hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. It sequences every pipeline register by generating per-stage stall (hold) and flush (bubble) strobes for four conditions: load-use hazards, taken branches resolved in EX, data-memory wait states and instruction-fetch wait states. It sits beside the operand-forwarding unit and covers the hazards forwarding cannot resolve. It also tracks memory-wait duration for a sticky timeout flag and keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_ctrl_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
// Holds the hazard FSM state, the per-cycle hazard cause and register-index constants.
package riscv_pipe_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    // Exactly one cause wins each cycle; HC_NONE means the pipeline advances freely.
    typedef enum logic [2:0] {
        HC_NONE     = 3'd0,
        HC_FREEZE   = 3'd1,
        HC_BRANCH   = 3'd2,
        HC_LOAD_USE = 3'd3,
        HC_IFETCH   = 3'd4
    } hz_cause_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Valid/ready semantics do not apply: every signal is level-sampled once per clock.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import riscv_pipe_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1_idx;
    logic [REG_IDX_W-1:0] id_rs2_idx;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [REG_IDX_W-1:0] id_ex_rd_idx;
    logic                 id_ex_mem_read;
    logic                 ex_branch_taken;
    logic                 ex_mem_mem_req;
    logic                 dmem_ready;
    logic                 imem_ready;

    logic                 pc_stall;
    logic                 if_id_stall;
    logic                 if_id_flush;
    logic                 id_ex_stall;
    logic                 id_ex_flush;
    logic                 ex_mem_stall;
    logic                 mem_wb_flush;
    logic                 mem_timeout;
    logic [CNT_W-1:0]     stall_count;
    logic [CNT_W-1:0]     flush_count;
    hz_state_e            hz_state;

    modport master (
        output id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
        output id_ex_rd_idx, id_ex_mem_read, ex_branch_taken,
        output ex_mem_mem_req, dmem_ready, imem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  ex_mem_stall, mem_wb_flush, mem_timeout,
        input  stall_count, flush_count, hz_state
    );

    modport slave (
        input  id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
        input  id_ex_rd_idx, id_ex_mem_read, ex_branch_taken,
        input  ex_mem_mem_req, dmem_ready, imem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output ex_mem_stall, mem_wb_flush, mem_timeout,
        output stall_count, flush_count, hz_state
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: per-stage stall/flush strobes for freeze, branch, load-use and
// fetch-wait, plus a memory-wait timeout flag and saturating stall/flush counters.
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz_if
);

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] WAIT_MAX  = '1;

    logic      freeze;
    logic      load_use;
    logic      rs1_hit;
    logic      rs2_hit;
    hz_cause_e cause;

    hz_state_e       state_q,    state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q,  timeout_d;

    assign freeze   = hz_if.ex_mem_mem_req & ~hz_if.dmem_ready;
    assign rs1_hit  = (hz_if.id_ex_rd_idx == hz_if.id_rs1_idx) & hz_if.id_uses_rs1;
    assign rs2_hit  = (hz_if.id_ex_rd_idx == hz_if.id_rs2_idx) & hz_if.id_uses_rs2;
    assign load_use = hz_if.id_ex_mem_read & (hz_if.id_ex_rd_idx != X0_IDX) & (rs1_hit | rs2_hit);

    // A frozen branch stays pending in EX, so freeze simply outranks it here.
    always_comb begin
        cause = HC_NONE;
        if (rst) begin
            cause = HC_NONE;
        end else if (freeze) begin
            cause = HC_FREEZE;
        end else if (hz_if.ex_branch_taken) begin
            cause = HC_BRANCH;
        end else if (load_use) begin
            cause = HC_LOAD_USE;
        end else if (!hz_if.imem_ready) begin
            cause = HC_IFETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (freeze) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (!freeze) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // wait_cnt_d is the number of consecutive freeze cycles once this edge completes.
    always_comb begin
        timeout_d = timeout_q | (freeze & (wait_cnt_d >= TIMEOUT_C));
    end

    always_comb begin
        hz_if.pc_stall     = 1'b0;
        hz_if.if_id_stall  = 1'b0;
        hz_if.if_id_flush  = 1'b0;
        hz_if.id_ex_stall  = 1'b0;
        hz_if.id_ex_flush  = 1'b0;
        hz_if.ex_mem_stall = 1'b0;
        hz_if.mem_wb_flush = 1'b0;
        case (cause)
            HC_FREEZE: begin
                hz_if.pc_stall     = 1'b1;
                hz_if.if_id_stall  = 1'b1;
                hz_if.id_ex_stall  = 1'b1;
                hz_if.ex_mem_stall = 1'b1;
                hz_if.mem_wb_flush = 1'b1;
            end
            HC_BRANCH: begin
                hz_if.if_id_flush  = 1'b1;
                hz_if.id_ex_flush  = 1'b1;
            end
            HC_LOAD_USE: begin
                hz_if.pc_stall     = 1'b1;
                hz_if.if_id_stall  = 1'b1;
                hz_if.id_ex_flush  = 1'b1;
            end
            HC_IFETCH: begin
                hz_if.pc_stall     = 1'b1;
                hz_if.if_id_flush  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign hz_if.mem_timeout = timeout_q;
    assign hz_if.hz_state    = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hz_if.pc_stall),
        .count (hz_if.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cause == HC_BRANCH),
        .count (hz_if.flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: stimulus table, hand-written multi-cycle sequences and
// random traffic, all checked against a cycle-level model of the hazard rules.
module tb_hazard_ctrl;
    import riscv_pipe_pkg::*;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_FRZ  = 7'b1101011;
    localparam logic [6:0] S_BR   = 7'b0010100;
    localparam logic [6:0] S_LU   = 7'b1100100;
    localparam logic [6:0] S_IF   = 7'b1010000;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, mreq, dr, ir;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (hz)
    );

    int n_cmp = 0;
    int n_err = 0;

    int run_len = 0;
    bit m_to    = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input int rs1, input int rs2, input int rd, input bit u1,
                                 input bit u2, input bit mr, input bit br, input bit mreq,
                                 input bit dr, input bit ir);
        stim_t s;
        s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.u1 = u1; s.u2 = u2; s.mr = mr; s.br = br; s.mreq = mreq; s.dr = dr; s.ir = ir;
        return s;
    endfunction

    function automatic bit is_freeze(input stim_t s);
        return s.mreq && !s.dr;
    endfunction

    function automatic bit is_load_use(input stim_t s);
        return s.mr && (s.rd != 0) && ((s.rd == s.rs1 && s.u1) || (s.rd == s.rs2 && s.u2));
    endfunction

    // Strobe word {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}.
    function automatic logic [6:0] model_strobes(input stim_t s, input bit r);
        if (r)                return S_NONE;
        if (is_freeze(s))     return S_FRZ;
        if (s.br)             return S_BR;
        if (is_load_use(s))   return S_LU;
        if (!s.ir)            return S_IF;
        return S_NONE;
    endfunction

    task automatic drive(input stim_t s, input bit r);
        rst                = r;
        hz.id_rs1_idx      = s.rs1;
        hz.id_rs2_idx      = s.rs2;
        hz.id_ex_rd_idx    = s.rd;
        hz.id_uses_rs1     = s.u1;
        hz.id_uses_rs2     = s.u2;
        hz.id_ex_mem_read  = s.mr;
        hz.ex_branch_taken = s.br;
        hz.ex_mem_mem_req  = s.mreq;
        hz.dmem_ready      = s.dr;
        hz.imem_ready      = s.ir;
    endtask

    // Drives one cycle, compares everything at the falling edge, then advances the model.
    task automatic run_cycle(input stim_t s, input bit r, output logic [6:0] got, output logic got_to);
        logic [6:0] exp;
        drive(s, r);
        @(negedge clk);
        exp = model_strobes(s, r);
        got = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
               hz.id_ex_flush, hz.ex_mem_stall, hz.mem_wb_flush};
        got_to = hz.mem_timeout;
        check("strobes", 32'(got), 32'(exp));
        check("stall_count", 32'(hz.stall_count), 32'(m_stall));
        check("flush_count", 32'(hz.flush_count), 32'(m_flush));
        check("mem_timeout", 32'(hz.mem_timeout), 32'(m_to));
        check("mem_wait_state", 32'(hz.hz_state == HZ_MEM_WAIT), 32'(run_len > 0));
        @(posedge clk);
        if (r) begin
            run_len = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            run_len = is_freeze(s) ? run_len + 1 : 0;
            if (run_len >= TIMEOUT) m_to = 1'b1;
            if (exp[6] && m_stall < CMAX) m_stall++;
            if (exp == S_BR && m_flush < CMAX) m_flush++;
        end
        #1;
    endtask

    stim_t idle;
    stim_t lu_s;
    stim_t frz_s;
    vec_t  vecs[14];
    logic [6:0] got;
    logic       got_to;

    initial begin
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        lu_s  = mk(5, 0, 5, 1, 0, 1, 0, 0, 1, 1);
        frz_s = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        vecs[0]  = '{idle, S_NONE};
        vecs[1]  = '{lu_s, S_LU};
        vecs[2]  = '{mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 1), S_NONE};
        vecs[3]  = '{mk(5, 0, 5, 0, 0, 1, 0, 0, 1, 1), S_NONE};
        vecs[4]  = '{mk(1, 9, 9, 0, 1, 1, 0, 0, 1, 1), S_LU};
        vecs[5]  = '{mk(5, 0, 5, 1, 0, 1, 1, 0, 1, 1), S_BR};
        vecs[6]  = '{frz_s, S_FRZ};
        vecs[7]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1), S_FRZ};
        vecs[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), S_IF};
        vecs[9]  = '{mk(5, 0, 5, 1, 0, 1, 0, 0, 1, 0), S_LU};
        vecs[10] = '{mk(5, 0, 5, 1, 0, 0, 0, 0, 1, 1), S_NONE};
        vecs[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0), S_BR};
        vecs[12] = '{mk(5, 0, 5, 1, 0, 1, 0, 1, 0, 0), S_FRZ};
        vecs[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), S_NONE};

        // Reset with a live load-use on the inputs: strobes must stay low.
        @(posedge clk); #1;
        run_cycle(lu_s, 1'b1, got, got_to);
        run_cycle(lu_s, 1'b1, got, got_to);
        check("rst_strobes", 32'(got), 32'(S_NONE));

        for (int i = 0; i < 14; i++) begin
            if (i == 8) run_cycle(idle, 1'b1, got, got_to);
            run_cycle(vecs[i].s, 1'b0, got, got_to);
            check($sformatf("vec%0d_strobes", i), 32'(got), 32'(vecs[i].exp));
        end

        // Load-use once, then branch on top of the same load-use.
        run_cycle(idle, 1'b1, got, got_to);
        run_cycle(lu_s, 1'b0, got, got_to);
        run_cycle(idle, 1'b0, got, got_to);
        check("lu_stall_count", 32'(hz.stall_count), 32'd1);
        run_cycle(vecs[5].s, 1'b0, got, got_to);
        run_cycle(idle, 1'b0, got, got_to);
        check("br_flush_count", 32'(hz.flush_count), 32'd1);
        check("br_stall_count", 32'(hz.stall_count), 32'd1);

        // Three dmem wait cycles with a branch pending in EX the whole time.
        run_cycle(idle, 1'b1, got, got_to);
        for (int k = 0; k < 3; k++) begin
            run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 1'b0, got, got_to);
            check("dwait_freeze", 32'(got), 32'(S_FRZ));
        end
        run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1), 1'b0, got, got_to);
        check("dwait_branch_after", 32'(got), 32'(S_BR));
        run_cycle(idle, 1'b0, got, got_to);
        check("dwait_stall_count", 32'(hz.stall_count), 32'd3);
        check("dwait_flush_count", 32'(hz.flush_count), 32'd1);

        // Six freeze cycles: flag visible from the fifth, sticky until reset.
        run_cycle(idle, 1'b1, got, got_to);
        for (int k = 1; k <= 6; k++) begin
            run_cycle(frz_s, 1'b0, got, got_to);
            check($sformatf("timeout_c%0d", k), 32'(got_to), 32'(k >= 5));
        end
        run_cycle(idle, 1'b0, got, got_to);
        check("timeout_sticky", 32'(got_to), 32'd1);
        run_cycle(idle, 1'b0, got, got_to);
        check("timeout_sticky2", 32'(got_to), 32'd1);
        run_cycle(idle, 1'b1, got, got_to);
        run_cycle(idle, 1'b0, got, got_to);
        check("timeout_cleared", 32'(got_to), 32'd0);

        // Reset landing in the second freeze cycle.
        run_cycle(frz_s, 1'b0, got, got_to);
        run_cycle(frz_s, 1'b1, got, got_to);
        check("rst_in_freeze", 32'(got), 32'(S_NONE));
        run_cycle(idle, 1'b0, got, got_to);
        check("post_rst_state", 32'(hz.hz_state == HZ_MEM_WAIT), 32'd0);
        check("post_rst_stall", 32'(hz.stall_count), 32'd0);

        // Ten load-use cycles saturate a 3-bit counter.
        for (int k = 0; k < 10; k++) run_cycle(lu_s, 1'b0, got, got_to);
        run_cycle(idle, 1'b0, got, got_to);
        check("stall_saturate", 32'(hz.stall_count), 32'(CMAX));

        // Random traffic; small register range makes hazards frequent.
        run_cycle(idle, 1'b1, got, got_to);
        for (int k = 0; k < 400; k++) begin
            stim_t s;
            s = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8));
            run_cycle(s, ($urandom_range(0, 49) == 0), got, got_to);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
